// File: rtl/sram_1024x32_req_ctrl_if.sv
// Bus bundle between a core-side client, the request controller and the
// sram_1024x32 macro pins.
//   req_*      : valid/ready request channel (client -> controller)
//   resp_*     : first-word-fall-through read response channel (controller -> client)
//   init_done  : array clear sweep finished
//   sram_*     : macro pins (ce/we/addr/wd/wmask driven out, rd sampled in)
// Modport slave is the controller view; master is the client + macro view.
interface sram_1024x32_req_ctrl_if #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BITS-1:0]       req_wdata;
  logic [BITS/8-1:0]     req_bmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [BITS-1:0]       resp_data;
  logic                  init_done;
  logic                  sram_ce;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [BITS-1:0]       sram_wd;
  logic [BITS-1:0]       sram_wmask;
  logic [BITS-1:0]       sram_rd;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_bmask, resp_ready, sram_rd,
    output req_ready, resp_valid, resp_data, init_done,
    output sram_ce, sram_we, sram_addr, sram_wd, sram_wmask
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_bmask, resp_ready, sram_rd,
    input  req_ready, resp_valid, resp_data, init_done,
    input  sram_ce, sram_we, sram_addr, sram_wd, sram_wmask
  );
endinterface

// File: rtl/sram_1024x32_req_ctrl.sv
// Initiator-side controller for the sram_1024x32 macro.
// Accepts valid/ready read/write requests, drives the macro pins from
// registers one cycle after acceptance, samples rd two cycles after
// acceptance into a response FIFO, and optionally zero-fills the array
// after reset before accepting traffic.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : slave modport of sram_1024x32_req_ctrl_if (request, response,
//            init_done and macro pin signals)
module sram_1024x32_req_ctrl #(
  parameter int unsigned BITS           = 32,
  parameter int unsigned WORD_DEPTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned RESP_DEPTH     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  sram_1024x32_req_ctrl_if.slave        bus
);

  localparam int unsigned NBYTES = BITS / 8;
  localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int unsigned OCC_W  = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BITS-1:0]       wd_q, wd_d;
  logic [BITS-1:0]       wmask_q, wmask_d;
  logic                  init_done_q;

  // Read pipeline: s1 = pins driven this cycle, s2 = rd valid this cycle
  logic                  rd_s1_q, rd_s1_d;
  logic                  rd_s2_q;

  logic [BITS-1:0]       fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [OCC_W-1:0]      occ_c;
  logic                  ready_c;
  logic                  accept_c;
  logic                  push_c;
  logic                  pop_c;
  logic [BITS-1:0]       wmask_exp_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits: FIFO slots not yet claimed by stored or in-flight reads
  assign occ_c    = OCC_W'(cnt_q) + OCC_W'(rd_s1_q) + OCC_W'(rd_s2_q);
  assign ready_c  = !reset && (state_q == ST_RUN) && (occ_c < OCC_W'(RESP_DEPTH));
  assign accept_c = bus.req_valid && ready_c;
  assign push_c   = rd_s2_q;
  assign pop_c    = (cnt_q != '0) && bus.resp_ready;

  // Byte enables expanded to the bitwise macro mask
  always_comb begin
    wmask_exp_c = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      wmask_exp_c[8*i +: 8] = {8{bus.req_bmask[i]}};
    end
  end

  // Next state and next pin values
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ce_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wd_d      = '0;
    wmask_d   = '0;
    rd_s1_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ce_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = clr_cnt_q;
        wmask_d = '1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          ce_d    = 1'b1;
          we_d    = bus.req_write;
          addr_d  = bus.req_addr;
          rd_s1_d = !bus.req_write;
          if (bus.req_write) begin
            wd_d    = bus.req_wdata;
            wmask_d = wmask_exp_c;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  // State, pin registers and read pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      clr_cnt_q   <= '0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      wmask_q     <= '0;
      rd_s1_q     <= 1'b0;
      rd_s2_q     <= 1'b0;
      init_done_q <= (CLEAR_ON_RESET == 0);
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      wmask_q     <= wmask_d;
      rd_s1_q     <= rd_s1_d;
      rd_s2_q     <= rd_s1_q;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; rd is captured in the cycle it is guaranteed valid
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= bus.sram_rd;
  end

  assign bus.req_ready  = ready_c;
  assign bus.resp_valid = (cnt_q != '0);
  assign bus.resp_data  = fifo_mem[rd_ptr_q];
  assign bus.init_done  = init_done_q;
  assign bus.sram_ce    = ce_q;
  assign bus.sram_we    = we_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wd    = wd_q;
  assign bus.sram_wmask = wmask_q;

endmodule

// File: tb/tb_sram_1024x32_req_ctrl.sv
// Bench for sram_1024x32_req_ctrl: one instance with the clear sweep, one
// without, each in front of a behavioural macro model.
module tb_sram_1024x32_req_ctrl;

  localparam int unsigned BITS  = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1024;

  logic clk;
  logic rst_a;
  logic rst_b;

  sram_1024x32_req_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(AW)) ifa ();
  sram_1024x32_req_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(AW)) ifb ();

  sram_1024x32_req_ctrl #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESP_DEPTH(4), .CLEAR_ON_RESET(1)
  ) u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (ifa)
  );

  sram_1024x32_req_ctrl #(
    .BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RESP_DEPTH(4), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  int win_pops = 0;
  int win_gaps = 0;
  int last_pop = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] ref_a [DEPTH];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Macro models: write with bit mask, read data valid for one cycle only
  always @(posedge clk) begin
    if (ifa.sram_ce && ifa.sram_we)
      mem_a[ifa.sram_addr] <= (mem_a[ifa.sram_addr] & ~ifa.sram_wmask) | (ifa.sram_wd & ifa.sram_wmask);
    if (ifa.sram_ce && !ifa.sram_we) ifa.sram_rd <= mem_a[ifa.sram_addr];
    else                             ifa.sram_rd <= $urandom;
    if (ifb.sram_ce && ifb.sram_we)
      mem_b[ifb.sram_addr] <= (mem_b[ifb.sram_addr] & ~ifb.sram_wmask) | (ifb.sram_wd & ifb.sram_wmask);
    if (ifb.sram_ce && !ifb.sram_we) ifb.sram_rd <= mem_b[ifb.sram_addr];
    else                             ifb.sram_rd <= $urandom;
  end

  // Response scoreboard for instance a
  initial forever begin
    @(negedge clk);
    if (ifa.resp_valid && ifa.resp_ready) begin
      check_eq("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check_eq("resp_data", 64'(ifa.resp_data), 64'(exp_q.pop_front()));
      if (win_pops > 0 && cyc != last_pop + 1) win_gaps++;
      last_pop = cyc;
      win_pops++;
    end
  end

  // Present one request on a and hold it until accepted
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd, input logic [3:0] bm);
    int n;
    n = 0;
    ifa.req_valid = 1'b1;
    ifa.req_write = wr;
    ifa.req_addr  = addr;
    ifa.req_wdata = wd;
    ifa.req_bmask = bm;
    @(negedge clk);
    while (!ifa.req_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!ifa.req_ready) begin
      check_eq("req_accept_timeout", 64'(ifa.req_ready), 64'd1);
    end else if (wr) begin
      for (int i = 0; i < 4; i++) if (bm[i]) ref_a[addr][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_q.push_back(ref_a[addr]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.req_valid = 1'b0;
    ifa.req_write = 1'b0;
    ifa.req_addr  = '0;
    ifa.req_wdata = '0;
    ifa.req_bmask = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Called just after reset deasserts; follows the whole clear sweep
  task automatic check_sweep();
    int bad_idle, bad_pins, stale;
    logic ce0, rv0;
    logic [AW-1:0] first_addr;
    bad_idle = 0; bad_pins = 0; stale = 0;
    ce0 = 1'b1; rv0 = 1'b1; first_addr = '1;
    for (int k = 0; k <= 1024; k++) begin
      @(negedge clk);
      if (k < 1024 && (ifa.init_done || ifa.req_ready)) bad_idle++;
      if (k == 0) begin
        ce0 = ifa.sram_ce;
        rv0 = ifa.resp_valid;
      end else begin
        if (k == 1) first_addr = ifa.sram_addr;
        if (!(ifa.sram_ce && ifa.sram_we && ifa.sram_addr == AW'(k - 1) &&
              ifa.sram_wd == '0 && ifa.sram_wmask == '1)) bad_pins++;
      end
      if (ifa.resp_valid) stale++;
    end
    check_eq("sweep_ce_first_cycle", 64'(ce0), 64'd0);
    check_eq("sweep_resp_valid_first_cycle", 64'(rv0), 64'd0);
    check_eq("sweep_first_addr", 64'(first_addr), 64'd0);
    check_eq("sweep_idle_cycles_bad", 64'(bad_idle), 64'd0);
    check_eq("sweep_pin_cycles_bad", 64'(bad_pins), 64'd0);
    check_eq("sweep_stale_resp", 64'(stale), 64'd0);
    check_eq("init_done_after_sweep", 64'(ifa.init_done), 64'd1);
    check_eq("req_ready_after_sweep", 64'(ifa.req_ready), 64'd1);
    for (int i = 0; i < int'(DEPTH); i++) ref_a[i] = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, acc;
    logic [AW-1:0] a;
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_a();
    ifa.resp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = '0;
    ifb.req_wdata = '0;   ifb.req_bmask = '0;   ifb.resp_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
      ref_a[i] = mem_a[i];
    end

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sram_ce", 64'(ifa.sram_ce), 64'd0);
    check_eq("rst_sram_we", 64'(ifa.sram_we), 64'd0);
    check_eq("rst_sram_addr", 64'(ifa.sram_addr), 64'd0);
    check_eq("rst_sram_wmask", 64'(ifa.sram_wmask), 64'd0);
    check_eq("rst_resp_valid", 64'(ifa.resp_valid), 64'd0);
    check_eq("rst_req_ready", 64'(ifa.req_ready), 64'd0);
    check_eq("rst_init_done", 64'(ifa.init_done), 64'd0);
    check_eq("rst_b_init_done", 64'(ifb.init_done), 64'd1);

    // Instance without clear: ready at once, write then read back
    @(posedge clk); #1 rst_b = 1'b0;
    @(negedge clk);
    check_eq("b_req_ready_first", 64'(ifb.req_ready), 64'd1);
    check_eq("b_init_done_first", 64'(ifb.init_done), 64'd1);
    @(posedge clk); #1;
    ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_addr = 10'h2A5;
    ifb.req_wdata = 32'hDEADBEEF; ifb.req_bmask = 4'hF;
    @(negedge clk);
    check_eq("b_wr_accept", 64'(ifb.req_ready), 64'd1);
    @(posedge clk); #1 ifb.req_write = 1'b0;
    @(negedge clk);
    check_eq("b_rd_accept", 64'(ifb.req_ready), 64'd1);
    @(posedge clk); #1 ifb.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifb.resp_valid && n < 20);
    check_eq("b_read_latency", 64'(n), 64'd3);
    check_eq("b_read_data", 64'(ifb.resp_data), 64'hDEADBEEF);

    // Clear sweep after reset, then cleared top word reads zero
    @(posedge clk); #1 rst_a = 1'b0;
    check_sweep();
    send(1'b0, 10'h3FF, '0, '0);
    idle_a();
    drain();

    // Full then partial write, read back with latency check
    send(1'b1, 10'h005, 32'h12345678, 4'b1111);
    send(1'b1, 10'h005, 32'hAABBCCDD, 4'b0100);
    send(1'b0, 10'h005, '0, '0);
    idle_a();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.resp_valid && n < 20);
    check_eq("read_latency", 64'(n), 64'd3);
    check_eq("merged_data", 64'(ifa.resp_data), 64'h12BB5678);
    drain();

    // Back-to-back reads with resp_ready held high
    for (int i = 0; i < 16; i++) send(1'b1, AW'(i), 32'hC0DE0000 | 32'(i), 4'hF);
    stalls = 0;
    win_pops = 0;
    win_gaps = 0;
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0, '0);
    idle_a();
    drain();
    check_eq("b2b_stalls", 64'(stalls), 64'd0);
    check_eq("b2b_pops", 64'(win_pops), 64'd16);
    check_eq("b2b_gaps", 64'(win_gaps), 64'd0);

    // Backpressure: credits stop acceptance at four
    ifa.resp_ready = 1'b0;
    acc = 0;
    a = 10'h000;
    ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = a;
    repeat (12) begin
      @(negedge clk);
      if (ifa.req_ready) begin
        acc++;
        exp_q.push_back(ref_a[a]);
        a = a + AW'(1);
      end
      @(posedge clk);
      #1 ifa.req_addr = a;
    end
    idle_a();
    check_eq("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk);
    check_eq("bp_ready_low", 64'(ifa.req_ready), 64'd0);
    @(posedge clk); #1 ifa.resp_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_at_first_pop", 64'(ifa.req_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_ready_after_pop", 64'(ifa.req_ready), 64'd1);
    drain();

    // Reset with two reads in flight and two in the FIFO
    ifa.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), '0, '0);
    idle_a();
    rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    exp_q.delete();
    ifa.resp_ready = 1'b1;
    check_sweep();
    send(1'b0, 10'h005, '0, '0);
    idle_a();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
